// File: rtl/tidc_pkg.sv
// Shared definitions for the TileLink source-ID allocator and its helpers.
//   clog2   : ceiling log2, used to size pointers from a count
//   num_ids : number of IDs addressable by a given source-ID width
//   src_id_t: source-ID type at the default pool width
package tidc_pkg;

  localparam int SRC_ID_WIDTH = 4;

  typedef logic [SRC_ID_WIDTH-1:0] src_id_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int num_ids(input int id_width);
    return 1 << id_width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Priority starts at the requester after the last
// granted one; the pointer moves only when the caller confirms the grant.
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset (pointer returns to requester 0)
//   req      request vector
//   advance  grant accepted this cycle; latch the granted index
//   gnt      one-hot grant (zero when no request)
module rr_arbiter
  import tidc_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? clog2(N) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] gnt_idx;
  logic          found;

  // Two passes: indices above the last grant first, then wrap to the rest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j > int'(last_q))) begin
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
        found   = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j <= int'(last_q))) begin
        gnt[j]  = 1'b1;
        gnt_idx = PW'(j);
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (advance && found) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/source_id_pool.sv
// TileLink source-ID allocator shared by NUM_REQ requesters. Grants at most
// one free ID per cycle, searching the registered in-use bitmap from a
// rotating pointer, stores per-ID metadata and returns it on free.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   alloc_valid      per-requester allocation request
//   alloc_ready      one-hot grant (combinational)
//   alloc_meta       packed per-requester metadata
//   alloc_id         ID granted this cycle (meaningful while |alloc_ready)
//   dealloc_valid    free request
//   dealloc_id       ID to free
//   dealloc_meta     metadata stored for dealloc_id (combinational read)
//   inflight_count   number of IDs in use
//   all_free         no IDs in use
//   double_free_err  sticky flag: free seen on an ID not in use
//   err_clear        clears double_free_err (a same-cycle set wins)
module source_id_pool
  import tidc_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int NUM_REQ    = 2,
  parameter int META_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            alloc_valid,
  output logic [NUM_REQ-1:0]            alloc_ready,
  input  logic [NUM_REQ*META_WIDTH-1:0] alloc_meta,
  output logic [ID_WIDTH-1:0]           alloc_id,
  input  logic                          dealloc_valid,
  input  logic [ID_WIDTH-1:0]           dealloc_id,
  output logic [META_WIDTH-1:0]         dealloc_meta,
  output logic [ID_WIDTH:0]             inflight_count,
  output logic                          all_free,
  output logic                          double_free_err,
  input  logic                          err_clear
);

  localparam int NUM_IDS = num_ids(ID_WIDTH);

  logic [NUM_IDS-1:0]    in_use_q;
  logic [NUM_IDS-1:0]    in_use_d;
  logic [ID_WIDTH-1:0]   next_ptr_q;
  logic [ID_WIDTH:0]     count_q;
  logic                  err_q;
  logic [META_WIDTH-1:0] meta_q [NUM_IDS];

  logic [ID_WIDTH-1:0]   cand;
  logic [ID_WIDTH-1:0]   free_id;
  logic                  free_found;
  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    gnt;
  logic                  grant;
  logic [META_WIDTH-1:0] sel_meta;
  logic                  free_ok;
  logic                  free_bad;

  // Circular first-free search. Adding k to the pointer in ID_WIDTH bits
  // gives the mod-NUM_IDS wrap for free.
  always_comb begin
    cand       = '0;
    free_id    = '0;
    free_found = 1'b0;
    for (int k = 0; k < NUM_IDS; k++) begin
      cand = next_ptr_q + ID_WIDTH'(k);
      if (!free_found && !in_use_q[cand]) begin
        free_id    = cand;
        free_found = 1'b1;
      end
    end
  end

  // Requests are masked before arbitration so the rr pointer only sees
  // cycles that can actually grant.
  assign arb_req = (rst_n && free_found) ? alloc_valid : '0;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .advance(grant),
    .gnt    (gnt)
  );

  assign grant       = |gnt;
  assign alloc_ready = gnt;
  assign alloc_id    = free_id;

  always_comb begin
    sel_meta = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) sel_meta = alloc_meta[r*META_WIDTH +: META_WIDTH];
    end
  end

  // A free of the ID being granted this cycle lands in free_bad, since that
  // ID is clear in the registered bitmap.
  assign free_ok  = dealloc_valid &&  in_use_q[dealloc_id];
  assign free_bad = dealloc_valid && !in_use_q[dealloc_id];

  always_comb begin
    in_use_d = in_use_q;
    if (free_ok) in_use_d[dealloc_id] = 1'b0;
    if (grant)   in_use_d[free_id]    = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_use_q   <= '0;
      next_ptr_q <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      in_use_q <= in_use_d;
      if (grant) next_ptr_q <= free_id + 1'b1;
      unique case ({grant, free_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (free_bad)       err_q <= 1'b1;
      else if (err_clear) err_q <= 1'b0;
    end
  end

  // Metadata RAM carries no reset; entries are only read for IDs in use.
  always_ff @(posedge clk) begin
    if (rst_n && grant) meta_q[free_id] <= sel_meta;
  end

  assign dealloc_meta    = meta_q[dealloc_id];
  assign inflight_count  = count_q;
  assign all_free        = (count_q == '0);
  assign double_free_err = err_q;

endmodule

// File: tb/tb_source_id_pool.sv
module tb_source_id_pool;

  localparam int IDW = 4;
  localparam int NR  = 2;
  localparam int MW  = 8;
  localparam int NID = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   alloc_valid;
  logic [NR-1:0]   alloc_ready;
  logic [NR*MW-1:0] alloc_meta;
  logic [IDW-1:0]  alloc_id;
  logic            dealloc_valid;
  logic [IDW-1:0]  dealloc_id;
  logic [MW-1:0]   dealloc_meta;
  logic [IDW:0]    inflight_count;
  logic            all_free;
  logic            double_free_err;
  logic            err_clear;

  int n_cmp = 0;
  int n_bad = 0;

  source_id_pool #(.ID_WIDTH(IDW), .NUM_REQ(NR), .META_WIDTH(MW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_meta     (alloc_meta),
    .alloc_id       (alloc_id),
    .dealloc_valid  (dealloc_valid),
    .dealloc_id     (dealloc_id),
    .dealloc_meta   (dealloc_meta),
    .inflight_count (inflight_count),
    .all_free       (all_free),
    .double_free_err(double_free_err),
    .err_clear      (err_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pool as an array of flags, pointers as plain ints.
  bit          m_use [NID];
  logic [7:0]  m_meta[NID];
  int          m_ptr, m_rr, m_cnt;
  bit          m_err;
  bit          m_on = 1'b0;

  always @(negedge clk) begin
    int  exp_id, exp_r, did;
    bit  ok, bad;
    logic [NR-1:0] exp_ready;
    exp_id = -1;
    for (int k = 0; k < NID; k++)
      if (exp_id < 0 && !m_use[(m_ptr + k) % NID]) exp_id = (m_ptr + k) % NID;
    exp_r = -1;
    if (rst_n && exp_id >= 0)
      for (int i = 1; i <= NR; i++)
        if (exp_r < 0 && alloc_valid[(m_rr + i) % NR]) exp_r = (m_rr + i) % NR;
    exp_ready = '0;
    if (exp_r >= 0) exp_ready[exp_r] = 1'b1;
    did = int'(dealloc_id);
    if (m_on) begin
      chk("alloc_ready", 32'(alloc_ready), 32'(exp_ready));
      if (exp_r >= 0) chk("alloc_id", 32'(alloc_id), exp_id);
      chk("inflight_count", 32'(inflight_count), m_cnt);
      chk("all_free", 32'(all_free), (m_cnt == 0) ? 1 : 0);
      chk("double_free_err", 32'(double_free_err), 32'(m_err));
      if (rst_n && dealloc_valid && m_use[did]) chk("dealloc_meta", 32'(dealloc_meta), 32'(m_meta[did]));
    end
    if (!rst_n) begin
      for (int k = 0; k < NID; k++) m_use[k] = 1'b0;
      m_ptr = 0; m_rr = 0; m_cnt = 0; m_err = 1'b0; m_on = 1'b1;
    end else if (m_on) begin
      ok  = dealloc_valid &&  m_use[did];
      bad = dealloc_valid && !m_use[did];
      if (ok) begin m_use[did] = 1'b0; m_cnt--; end
      if (exp_r >= 0) begin
        m_use[exp_id]  = 1'b1;
        m_meta[exp_id] = alloc_meta[exp_r*MW +: MW];
        m_ptr = (exp_id + 1) % NID;
        m_rr  = exp_r;
        m_cnt++;
      end
      if (bad) m_err = 1'b1;
      else if (err_clear) m_err = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = '0; dealloc_valid = 1'b0; err_clear = 1'b0;
  endtask

  task automatic do_reset();
    tick(); rst_n = 1'b0; idle();
    mid();
    tick(); rst_n = 1'b1;
    mid();
    chk("rst_count", 32'(inflight_count), 0);
    chk("rst_all_free", 32'(all_free), 1);
  endtask

  initial begin
    int pick, nuse;
    int ulist[$];
    rst_n = 1'b0; alloc_valid = '0; alloc_meta = '0;
    dealloc_valid = 1'b0; dealloc_id = '0; err_clear = 1'b0;

    // Fill the pool from requester 0
    alloc_valid = 2'b01;
    tick(); tick(); mid();
    chk("rst_ready", 32'(alloc_ready), 0);
    chk("rst_err", 32'(double_free_err), 0);
    for (int i = 0; i < 16; i++) begin
      tick(); rst_n = 1'b1; alloc_meta[7:0] = 8'(8'h10 + i);
      mid();
      chk("fill_ready", 32'(alloc_ready), 1);
      chk("fill_id", 32'(alloc_id), i);
    end
    tick(); mid();
    chk("full_ready", 32'(alloc_ready), 0);
    chk("full_all_free", 32'(all_free), 0);
    chk("full_count", 32'(inflight_count), 16);

    // Free 5 on a full pool with alloc held: no grant until next cycle
    tick(); dealloc_valid = 1'b1; dealloc_id = 4'd5; alloc_meta[7:0] = 8'h55;
    mid();
    chk("full_free_ready", 32'(alloc_ready), 0);
    chk("free5_meta", 32'(dealloc_meta), 32'h15);
    tick(); dealloc_valid = 1'b0;
    mid();
    chk("after_free_count", 32'(inflight_count), 15);
    chk("regrant_id", 32'(alloc_id), 5);
    chk("regrant_ready", 32'(alloc_ready), 1);
    tick(); alloc_valid = '0;
    mid();
    chk("refill_count", 32'(inflight_count), 16);

    // Two requesters: grants alternate 1,0,1,0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(); alloc_valid = 2'b11; alloc_meta = 16'hB1A0;
      mid();
      chk("rr_ready", 32'(alloc_ready), (k % 2 == 0) ? 2 : 1);
      chk("rr_id", 32'(alloc_id), k);
    end
    for (int k = 0; k < 4; k++) begin
      tick(); alloc_valid = '0; dealloc_valid = 1'b1; dealloc_id = 4'(k);
      mid();
      chk("rr_meta", 32'(dealloc_meta), (k % 2 == 0) ? 32'hB1 : 32'hA0);
    end
    tick(); idle();

    // Rotating pointer: freed ID 1 is skipped until the search wraps
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(); alloc_valid = 2'b01; mid();
      chk("rot_id", 32'(alloc_id), k);
    end
    tick(); alloc_valid = '0; dealloc_valid = 1'b1; dealloc_id = 4'd1; mid();
    tick(); dealloc_valid = 1'b0; alloc_valid = 2'b01; mid();
    chk("rot_skip", 32'(alloc_id), 4);
    for (int k = 5; k < 16; k++) begin
      tick(); mid();
      chk("rot_fill", 32'(alloc_id), k);
    end
    tick(); mid();
    chk("rot_wrap", 32'(alloc_id), 1);
    tick(); alloc_valid = '0; mid();
    chk("rot_count", 32'(inflight_count), 16);

    // Illegal frees and sticky error
    do_reset();
    tick(); alloc_valid = 2'b01; mid();
    tick(); mid();
    tick(); alloc_valid = '0; dealloc_valid = 1'b1; dealloc_id = 4'd9; mid();
    chk("df_pre", 32'(double_free_err), 0);
    tick(); err_clear = 1'b1; mid();
    chk("df_set", 32'(double_free_err), 1);
    chk("df_count", 32'(inflight_count), 2);
    tick(); dealloc_valid = 1'b0; mid();
    chk("df_priority", 32'(double_free_err), 1);
    tick(); err_clear = 1'b0; mid();
    chk("df_cleared", 32'(double_free_err), 0);
    chk("df_count2", 32'(inflight_count), 2);

    // Free of the ID being granted in the same cycle
    do_reset();
    tick(); alloc_valid = 2'b01; dealloc_valid = 1'b1; dealloc_id = 4'd0; mid();
    chk("same_id", 32'(alloc_id), 0);
    tick(); idle(); mid();
    chk("same_count", 32'(inflight_count), 1);
    chk("same_err", 32'(double_free_err), 1);

    // Reset with 7 in flight
    do_reset();
    for (int k = 0; k < 7; k++) begin tick(); alloc_valid = 2'b01; mid(); end
    tick(); rst_n = 1'b0; alloc_valid = '0; mid();
    tick(); rst_n = 1'b1; alloc_valid = 2'b01; mid();
    chk("mid_rst_count", 32'(inflight_count), 0);
    chk("mid_rst_all_free", 32'(all_free), 1);
    chk("mid_rst_id", 32'(alloc_id), 0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      alloc_valid = NR'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) alloc_valid = '0;
      alloc_meta = 16'($urandom);
      err_clear = ($urandom_range(0, 15) == 0);
      dealloc_valid = ($urandom_range(0, 2) != 0);
      ulist.delete();
      for (int k = 0; k < NID; k++) if (m_use[k]) ulist.push_back(k);
      nuse = ulist.size();
      if (nuse > 0 && $urandom_range(0, 7) != 0) begin
        pick = int'($urandom_range(0, nuse - 1));
        dealloc_id = 4'(ulist[pick]);
      end else begin
        dealloc_id = 4'($urandom_range(0, 15));
      end
      mid();
    end
    tick(); idle(); rst_n = 1'b1;
    mid(); mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
